// File: rtl/pcie_rx_decode.sv
// Receive-side TLP decoder for the 64-bit RX stream: classifies MWr/MRd/CplD,
// realigns payload into endian-swapped qwords and counts dropped TLPs.
module pcie_rx_decode #(
    parameter int AW        = 13,
    parameter int CI_W      = 4,
    parameter bit EN_ADDR64 = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            tvalid,
    input  logic            tlast,
    input  logic [63:0]     tdata,
    output logic            write_valid,
    output logic            read_valid,
    output logic            completion_valid,
    output logic [63:0]     data,
    output logic            upper_valid,
    output logic [AW-1:0]   address,
    output logic [9:0]      read_len,
    output logic [31:0]     rr_rc_dw2,
    output logic [7:0]      completion_tag,
    output logic [CI_W-1:0] completion_index,
    output logic [15:0]     drop_count
);
    typedef enum logic [1:0] {HDR01, HDR23, DATA} state_t;

    function automatic logic [31:0] es(input logic [31:0] dw);
        return {dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
    endfunction

    state_t          r_state;
    logic            r_vld_p0;
    logic            r_last_p0;
    logic [63:0]     r_tdata_p0;
    logic            r_is_wr;
    logic            r_is_rd;
    logic            r_is_cpl;
    logic            r_is_4dw;
    logic            r_drop;
    logic            r_flush;
    logic [9:0]      r_len;
    logic [23:0]     r_req_tag;
    logic [31:0]     r_prev_hi;
    logic [AW-1:0]   r_waddr;
    logic [CI_W-1:0] r_cidx;

    logic            r_write_valid;
    logic            r_read_valid;
    logic            r_cpl_valid;
    logic            r_upper_valid;
    logic [63:0]     r_data;
    logic [AW-1:0]   r_address;
    logic [9:0]      r_read_len;
    logic [31:0]     r_rr_rc_dw2;
    logic [7:0]      r_cpl_tag;
    logic [CI_W-1:0] r_cpl_index;
    logic [15:0]     r_drop_count;

    logic [31:0]     w_lo;
    logic [31:0]     w_hi;
    logic [31:0]     w_adw;
    logic [6:0]      w_fmt_type;
    logic            w_mwr32;
    logic            w_mwr64;
    logic            w_mrd32;
    logic            w_mrd64;
    logic            w_cpld;
    logic            w_4dw;
    logic            w_drop;
    logic            w_last_odd;
    logic            w_odd_flush;
    logic [63:0]     w_payload;
    logic            w_payload_upper;
    logic [AW-1:0]   w_hdr_addr;
    logic [CI_W-1:0] w_hdr_cidx;
    logic            w_unused;

    // stage p0: register the raw RX beat
    always_ff @(posedge clock) begin
        r_tdata_p0 <= tdata;
        if (reset) begin
            r_vld_p0  <= 1'b0;
            r_last_p0 <= 1'b0;
        end else begin
            r_vld_p0  <= tvalid;
            r_last_p0 <= tlast;
        end
    end

    always_comb begin
        w_lo       = r_tdata_p0[31:0];
        w_hi       = r_tdata_p0[63:32];
        w_fmt_type = w_lo[30:24];
        w_mwr32    = (w_fmt_type == 7'h40);
        w_mwr64    = (w_fmt_type == 7'h60);
        w_mrd32    = (w_fmt_type == 7'h00);
        w_mrd64    = (w_fmt_type == 7'h20);
        w_cpld     = (w_fmt_type == 7'h4A);
        w_4dw      = w_mwr64 || w_mrd64;
        w_drop     = !(w_mwr32 || w_mwr64 || w_mrd32 || w_mrd64 || w_cpld)
                     || w_lo[14] || (w_4dw && !EN_ADDR64);
        w_adw      = r_is_4dw ? w_hi : w_lo;
        w_hdr_addr = w_adw[AW+2:3];
        w_hdr_cidx = CI_W'(w_lo[6:3]);
        w_last_odd = r_last_p0 && r_len[0];
        // 4DW payload is qword-aligned; 3DW payload straddles beats by one DW
        if (r_is_4dw) begin
            w_payload_upper = !w_last_odd;
            w_payload       = w_last_odd ? {32'h0, es(w_lo)} : {es(w_hi), es(w_lo)};
        end else begin
            w_payload_upper = 1'b1;
            w_payload       = {es(w_lo), es(r_prev_hi)};
        end
        w_odd_flush = w_last_odd && !r_is_4dw && !r_drop && (r_is_wr || r_is_cpl);
        w_unused    = ^w_adw;
    end

    // stage p1: header decode, payload emit and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= HDR01;
            r_is_wr       <= 1'b0;
            r_is_rd       <= 1'b0;
            r_is_cpl      <= 1'b0;
            r_is_4dw      <= 1'b0;
            r_drop        <= 1'b0;
            r_flush       <= 1'b0;
            r_len         <= '0;
            r_req_tag     <= '0;
            r_prev_hi     <= '0;
            r_waddr       <= '0;
            r_cidx        <= '0;
            r_write_valid <= 1'b0;
            r_read_valid  <= 1'b0;
            r_cpl_valid   <= 1'b0;
            r_upper_valid <= 1'b0;
            r_data        <= '0;
            r_address     <= '0;
            r_read_len    <= '0;
            r_rr_rc_dw2   <= '0;
            r_cpl_tag     <= '0;
            r_cpl_index   <= '0;
            r_drop_count  <= '0;
        end else begin
            r_write_valid <= 1'b0;
            r_read_valid  <= 1'b0;
            r_cpl_valid   <= 1'b0;

            // leftover DW of an odd 3DW TLP; lands in the next TLP's header slot
            if (r_flush) begin
                r_flush       <= 1'b0;
                r_data        <= {32'h0, es(r_prev_hi)};
                r_upper_valid <= 1'b0;
                if (r_is_cpl) begin
                    r_cpl_valid <= 1'b1;
                    r_cpl_index <= r_cidx;
                end else begin
                    r_write_valid <= 1'b1;
                    r_address     <= r_waddr;
                end
            end

            if (r_vld_p0) begin
                case (r_state)
                    HDR01: begin
                        r_is_wr   <= w_mwr32 || w_mwr64;
                        r_is_rd   <= w_mrd32 || w_mrd64;
                        r_is_cpl  <= w_cpld;
                        r_is_4dw  <= w_4dw;
                        r_drop    <= w_drop;
                        r_len     <= w_lo[9:0];
                        r_req_tag <= w_hi[31:8];
                        if (w_drop && r_drop_count != 16'hFFFF)
                            r_drop_count <= r_drop_count + 16'd1;
                        r_state   <= HDR23;
                    end
                    HDR23: begin
                        r_waddr   <= w_hdr_addr;
                        r_cidx    <= w_hdr_cidx;
                        r_prev_hi <= w_hi;
                        if (!r_drop && r_is_cpl)
                            r_cpl_tag <= w_lo[15:8];
                        if (!r_drop && r_is_rd) begin
                            r_read_valid <= 1'b1;
                            r_address    <= w_hdr_addr;
                            r_read_len   <= r_len;
                            r_rr_rc_dw2  <= {r_req_tag, 1'b0, w_adw[6:3], 3'd0};
                        end
                        if (w_odd_flush)
                            r_flush <= 1'b1;
                        r_state <= DATA;
                    end
                    DATA: begin
                        r_prev_hi <= w_hi;
                        if (!r_drop && (r_is_wr || r_is_cpl)) begin
                            r_data        <= w_payload;
                            r_upper_valid <= w_payload_upper;
                            if (r_is_cpl) begin
                                r_cpl_valid <= 1'b1;
                                r_cpl_index <= r_cidx;
                                r_cidx      <= r_cidx + 1'b1;
                            end else begin
                                r_write_valid <= 1'b1;
                                r_address     <= r_waddr;
                                r_waddr       <= r_waddr + 1'b1;
                            end
                        end
                        if (w_odd_flush)
                            r_flush <= 1'b1;
                    end
                    default: r_state <= HDR01;
                endcase
                if (r_last_p0)
                    r_state <= HDR01;
            end
        end
    end

    assign write_valid      = r_write_valid;
    assign read_valid       = r_read_valid;
    assign completion_valid = r_cpl_valid;
    assign data             = r_data;
    assign upper_valid      = r_upper_valid;
    assign address          = r_address;
    assign read_len         = r_read_len;
    assign rr_rc_dw2        = r_rr_rc_dw2;
    assign completion_tag   = r_cpl_tag;
    assign completion_index = r_cpl_index;
    assign drop_count       = r_drop_count;

endmodule

// File: tb/tb_pcie_rx_decode.sv
// Directed bench for pcie_rx_decode: hand-computed TLP vectors, logged output pulses.
module tb_pcie_rx_decode;
    localparam int AW   = 13;
    localparam int CI_W = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            tvalid;
    logic            tlast;
    logic [63:0]     tdata;
    logic            write_valid;
    logic            read_valid;
    logic            completion_valid;
    logic [63:0]     data;
    logic            upper_valid;
    logic [AW-1:0]   address;
    logic [9:0]      read_len;
    logic [31:0]     rr_rc_dw2;
    logic [7:0]      completion_tag;
    logic [CI_W-1:0] completion_index;
    logic [15:0]     drop_count;

    always #5 clock = ~clock;

    pcie_rx_decode #(.AW(AW), .CI_W(CI_W), .EN_ADDR64(1'b1)) dut (
        .clock(clock), .reset(reset), .tvalid(tvalid), .tlast(tlast), .tdata(tdata),
        .write_valid(write_valid), .read_valid(read_valid),
        .completion_valid(completion_valid), .data(data), .upper_valid(upper_valid),
        .address(address), .read_len(read_len), .rr_rc_dw2(rr_rc_dw2),
        .completion_tag(completion_tag), .completion_index(completion_index),
        .drop_count(drop_count)
    );

    int n_tests   = 0;
    int n_fail    = 0;
    int n_overlap = 0;
    int rd_cnt    = 0;
    logic [63:0] wr_addr[$];
    logic [63:0] wr_data[$];
    logic [63:0] wr_up[$];
    logic [63:0] cpl_tag[$];
    logic [63:0] cpl_idx[$];
    logic [63:0] cpl_data[$];

    always @(negedge clock) begin
        if (write_valid === 1'b1) begin
            wr_addr.push_back(64'(address));
            wr_data.push_back(data);
            wr_up.push_back(64'(upper_valid));
        end
        if (read_valid === 1'b1)
            rd_cnt++;
        if (completion_valid === 1'b1) begin
            cpl_tag.push_back(64'(completion_tag));
            cpl_idx.push_back(64'(completion_index));
            cpl_data.push_back(data);
        end
        if ((32'(write_valid) + 32'(read_valid) + 32'(completion_valid)) > 1)
            n_overlap++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pick(input logic [63:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic beat(input logic l, input logic [63:0] d);
        tvalid = 1'b1;
        tlast  = l;
        tdata  = d;
        @(posedge clock);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        wr_up.delete();
        cpl_tag.delete();
        cpl_idx.delete();
        cpl_data.delete();
        rd_cnt = 0;
    endtask

    initial begin
        reset  = 1'b1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
        idle(3);
        check("rst write_valid", 64'(write_valid), 64'd0);
        check("rst read_valid", 64'(read_valid), 64'd0);
        check("rst cpl_valid", 64'(completion_valid), 64'd0);
        check("rst data", data, 64'd0);
        check("rst upper_valid", 64'(upper_valid), 64'd0);
        check("rst address", 64'(address), 64'd0);
        check("rst rr_rc_dw2", 64'(rr_rc_dw2), 64'd0);
        check("rst drop_count", 64'(drop_count), 64'd0);
        reset = 1'b0;
        idle(2);
        clear_logs();

        // MWr32 addr 0x100, 4 DW
        beat(1'b0, 64'h010001FF_40000004);
        beat(1'b0, 64'h11223344_00000100);
        beat(1'b0, 64'h99AABBCC_55667788);
        beat(1'b1, 64'h00000000_DDEEFF00);
        idle(4);
        check("mwr32 count", 64'(wr_addr.size()), 64'd2);
        check("mwr32 addr0", pick(wr_addr, 0), 64'h020);
        check("mwr32 data0", pick(wr_data, 0), 64'h88776655_44332211);
        check("mwr32 up0", pick(wr_up, 0), 64'd1);
        check("mwr32 addr1", pick(wr_addr, 1), 64'h021);
        check("mwr32 data1", pick(wr_data, 1), 64'h00FFEEDD_CCBBAA99);
        check("mwr32 up1", pick(wr_up, 1), 64'd1);
        clear_logs();

        // MWr64 addr 0x1_0000_0040, 3 DW
        beat(1'b0, 64'h010001FF_60000003);
        beat(1'b0, 64'h00000040_00000001);
        beat(1'b0, 64'hB1B2B3B4_A1A2A3A4);
        beat(1'b1, 64'h00000000_C1C2C3C4);
        idle(4);
        check("mwr64 count", 64'(wr_addr.size()), 64'd2);
        check("mwr64 addr0", pick(wr_addr, 0), 64'h008);
        check("mwr64 data0", pick(wr_data, 0), 64'hB4B3B2B1_A4A3A2A1);
        check("mwr64 up0", pick(wr_up, 0), 64'd1);
        check("mwr64 addr1", pick(wr_addr, 1), 64'h009);
        check("mwr64 data1", pick(wr_data, 1), 64'h00000000_C4C3C2C1);
        check("mwr64 up1", pick(wr_up, 1), 64'd0);
        clear_logs();

        // MRd32 len 1, tag 0x05, req 0x0100, addr 0x18; pulse two cycles after address beat
        beat(1'b0, 64'h010005FF_00000001);
        beat(1'b1, 64'h00000000_00000018);
        check("mrd early", 64'(read_valid), 64'd0);
        idle(1);
        check("mrd latency", 64'(read_valid), 64'd1);
        check("mrd address", 64'(address), 64'd3);
        check("mrd read_len", 64'(read_len), 64'd1);
        check("mrd rr_rc_dw2", 64'(rr_rc_dw2), 64'h01000518);
        idle(4);
        check("mrd pulses", 64'(rd_cnt), 64'd1);
        check("mrd no writes", 64'(wr_addr.size()), 64'd0);
        clear_logs();

        // CplD tag 0x07, lower_addr 0x08, 4 DW
        beat(1'b0, 64'h00000010_4A000004);
        beat(1'b0, 64'h11223344_01000708);
        beat(1'b0, 64'h99AABBCC_55667788);
        beat(1'b1, 64'h00000000_DDEEFF00);
        idle(4);
        check("cpl count", 64'(cpl_tag.size()), 64'd2);
        check("cpl tag", pick(cpl_tag, 0), 64'h07);
        check("cpl idx0", pick(cpl_idx, 0), 64'd1);
        check("cpl idx1", pick(cpl_idx, 1), 64'd2);
        check("cpl data0", pick(cpl_data, 0), 64'h88776655_44332211);
        check("cpl data1", pick(cpl_data, 1), 64'h00FFEEDD_CCBBAA99);
        clear_logs();

        // CplD lower_addr 0x78: index wraps 15 -> 0
        beat(1'b0, 64'h00000010_4A000004);
        beat(1'b0, 64'h11223344_01000778);
        beat(1'b0, 64'h99AABBCC_55667788);
        beat(1'b1, 64'h00000000_DDEEFF00);
        idle(4);
        check("cplw count", 64'(cpl_idx.size()), 64'd2);
        check("cplw idx0", pick(cpl_idx, 0), 64'd15);
        check("cplw idx1", pick(cpl_idx, 1), 64'd0);
        clear_logs();

        // Poisoned MWr32 then Msg: both dropped
        beat(1'b0, 64'h010001FF_40004004);
        beat(1'b0, 64'h11223344_00000100);
        beat(1'b0, 64'h99AABBCC_55667788);
        beat(1'b1, 64'h00000000_DDEEFF00);
        beat(1'b0, 64'h010001FF_30000000);
        beat(1'b1, 64'h00000000_00000000);
        idle(4);
        check("drop count2", 64'(drop_count), 64'd2);
        check("drop no wr", 64'(wr_addr.size()), 64'd0);
        check("drop no cpl", 64'(cpl_tag.size()), 64'd0);
        check("drop no rd", 64'(rd_cnt), 64'd0);

        // drive to saturation, then one more drop
        for (int i = 0; i < 65533; i++)
            beat(1'b1, 64'h00000000_30000000);
        idle(3);
        check("drop at max", 64'(drop_count), 64'hFFFF);
        beat(1'b1, 64'h00000000_30000000);
        idle(3);
        check("drop saturate", 64'(drop_count), 64'hFFFF);
        check("drop sat no wr", 64'(wr_addr.size()), 64'd0);
        clear_logs();

        // reset after beat 1 of an MWr32, then a clean MRd32
        beat(1'b0, 64'h010001FF_40000004);
        beat(1'b0, 64'h11223344_00000100);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("midrst drop_count", 64'(drop_count), 64'd0);
        beat(1'b0, 64'h010009FF_00000002);
        beat(1'b1, 64'h00000000_00000028);
        idle(4);
        check("midrst no writes", 64'(wr_addr.size()), 64'd0);
        check("midrst rd pulses", 64'(rd_cnt), 64'd1);
        check("midrst address", 64'(address), 64'd5);
        check("midrst read_len", 64'(read_len), 64'd2);
        check("midrst rr_rc_dw2", 64'(rr_rc_dw2), 64'h01000928);
        clear_logs();

        // back-to-back odd MWr32: len 3 @0x200 then len 1 @0x300
        beat(1'b0, 64'h010001FF_40000003);
        beat(1'b0, 64'h01020304_00000200);
        beat(1'b1, 64'h090A0B0C_05060708);
        beat(1'b0, 64'h010001FF_40000001);
        beat(1'b1, 64'hAABBCCDD_00000300);
        idle(4);
        check("odd count", 64'(wr_addr.size()), 64'd3);
        check("odd addr0", pick(wr_addr, 0), 64'h040);
        check("odd data0", pick(wr_data, 0), 64'h08070605_04030201);
        check("odd up0", pick(wr_up, 0), 64'd1);
        check("odd flush addr", pick(wr_addr, 1), 64'h041);
        check("odd flush data", pick(wr_data, 1), 64'h00000000_0C0B0A09);
        check("odd flush up", pick(wr_up, 1), 64'd0);
        check("odd2 flush addr", pick(wr_addr, 2), 64'h060);
        check("odd2 flush data", pick(wr_data, 2), 64'h00000000_DDCCBBAA);
        check("odd2 flush up", pick(wr_up, 2), 64'd0);
        check("held read_len", 64'(read_len), 64'd2);
        check("held rr_rc_dw2", 64'(rr_rc_dw2), 64'h01000928);
        check("valid exclusive", 64'(n_overlap), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
